// File: rtl/acc_pkg.sv
// Shared types and the widen/add/clamp helper for the multi-channel accumulator.
package acc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Working width for sat_add; operands arrive sign-extended to this width,
  // which leaves headroom well beyond SUM_W+1 for any legal SUM_W.
  localparam int SAT_W = 64;

  // Returns {value, ovf}. value is the stored SUM_W-bit result, sign-extended
  // to SAT_W bits; ovf flags a true sum outside the signed sum_w-bit range.
  function automatic logic [SAT_W:0] sat_add(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] x,
    input logic                    clr,
    input logic                    sat_en,
    input int unsigned             sum_w
  );
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    logic signed [SAT_W-1:0] val;
    logic                    ovf;
    r    = clr ? x : acc + x;
    maxv = (SAT_W'(1) <<< (sum_w - 1)) - SAT_W'(1);
    minv = -maxv - SAT_W'(1);
    ovf  = (r > maxv) || (r < minv);
    if (!ovf) begin
      val = r;
    end else if (sat_en) begin
      val = r[SAT_W-1] ? minv : maxv;
    end else begin
      // keep the low sum_w bits, re-extended from bit sum_w-1
      val = (r <<< (SAT_W - sum_w)) >>> (SAT_W - sum_w);
    end
    return {val, ovf};
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational widen/add/clamp of one sample into one channel sum.
module acc_sat_add
  import acc_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SUM_W = 20
) (
  input  logic [SUM_W-1:0] acc_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic             clr_i,
  input  logic             sat_en_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             ovf_o
);

  if (SUM_W < IN_W) begin : g_bad_sum_w
    $error("acc_sat_add: SUM_W must be >= IN_W");
  end
  if (SUM_W > SAT_W - 2) begin : g_bad_sat_w
    $error("acc_sat_add: SUM_W exceeds sat_add working width");
  end

  logic [SAT_W:0] res;

  // Sign-extend both operands and evaluate the helper.
  always_comb begin
    res = sat_add(SAT_W'(signed'(acc_i)), SAT_W'(signed'(data_i)),
                  clr_i, sat_en_i, SUM_W);
  end

  assign sum_o = SUM_W'(res >> 1);
  assign ovf_o = res[0];

endmodule

// File: rtl/acc_multi.sv
// Multi-channel signed accumulator with wrap/saturate, sticky overflow flags,
// per-channel clear-and-load and a flush sequence that dumps and clears all sums.
module acc_multi
  import acc_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SUM_W = 20,
  parameter int NCH   = 4,
  parameter int CH_W  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             in_clr,
  input  logic             sat_en,
  input  logic             flush_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_ovf,
  output logic             out_flush,
  output logic             busy,
  output logic             err
);

  if (SUM_W < IN_W) begin : g_bad_sum_w
    $error("acc_multi: SUM_W must be >= IN_W");
  end
  if (NCH < 2) begin : g_bad_nch
    $error("acc_multi: NCH must be >= 2");
  end

  state_t            state_q, state_d;
  logic [CH_W-1:0]   flush_idx_q, flush_idx_d;
  logic              last_sent_q, last_sent_d;
  logic [SUM_W-1:0]  acc_q [NCH];
  logic [SUM_W-1:0]  acc_d [NCH];
  logic              ovf_q [NCH];
  logic              ovf_d [NCH];
  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_flush_q, out_flush_d;
  logic              err_q, err_d;

  logic              slot_free;
  logic              accept;
  logic              ch_ok;
  logic [CH_W-1:0]   ch_idx;
  logic [SUM_W-1:0]  add_sum;
  logic              add_ovf;
  logic              new_ovf;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign ch_ok     = {1'b0, in_ch} < (CH_W+1)'(NCH);
  assign ch_idx    = ch_ok ? in_ch : '0;
  assign new_ovf   = (in_clr ? 1'b0 : ovf_q[ch_idx]) | add_ovf;

  acc_sat_add #(
    .IN_W  (IN_W),
    .SUM_W (SUM_W)
  ) u_add (
    .acc_i    (acc_q[ch_idx]),
    .data_i   (in_data),
    .clr_i    (in_clr),
    .sat_en_i (sat_en),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  // State, channel storage and output register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      last_sent_q <= 1'b0;
      acc_q       <= '{default: '0};
      ovf_q       <= '{default: 1'b0};
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
      out_flush_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      last_sent_q <= last_sent_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ch_q    <= out_ch_d;
      out_ovf_q   <= out_ovf_d;
      out_flush_q <= out_flush_d;
      err_q       <= err_d;
    end
  end

  // Next-state: beat updates in IDLE, channel-by-channel dump in FLUSH.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    last_sent_d = last_sent_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ch_d    = out_ch_q;
    out_ovf_d   = out_ovf_q;
    out_flush_d = out_flush_q;
    err_d       = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ch_ok) begin
            acc_d[ch_idx] = add_sum;
            ovf_d[ch_idx] = new_ovf;
            out_valid_d   = 1'b1;
            out_sum_d     = add_sum;
            out_ch_d      = in_ch;
            out_ovf_d     = new_ovf;
            out_flush_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        if (flush_req) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
          last_sent_d = 1'b0;
        end
      end
      FLUSH: begin
        if (!last_sent_q && slot_free) begin
          out_valid_d        = 1'b1;
          out_sum_d          = acc_q[flush_idx_q];
          out_ch_d           = flush_idx_q;
          out_ovf_d          = ovf_q[flush_idx_q];
          out_flush_d        = 1'b1;
          acc_d[flush_idx_q] = '0;
          ovf_d[flush_idx_q] = 1'b0;
          if (flush_idx_q == CH_W'(NCH - 1)) begin
            last_sent_d = 1'b1;
          end else begin
            flush_idx_d = flush_idx_q + 1'b1;
          end
        end else if (last_sent_q && out_valid_q && out_ready) begin
          state_d     = IDLE;
          flush_idx_d = '0;
          last_sent_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;
  assign out_flush = out_flush_q;
  assign busy      = (state_q == FLUSH);
  assign err       = err_q;

endmodule

// File: tb/tb_acc_multi.sv
// Directed bench for acc_multi: a default 4-channel instance plus a 3-channel
// instance for the out-of-range channel case.
module tb_acc_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_clr = 1'b0, sat_en = 1'b0, flush_req = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_ch = '0;
  logic        in_ready, out_valid, out_ovf, out_flush, busy, err;
  logic [19:0] out_sum;
  logic [1:0]  out_ch;

  logic        in3_valid = 1'b0;
  logic [15:0] in3_data = '0;
  logic [1:0]  in3_ch = '0;
  logic        in3_ready, out3_valid, out3_ovf, out3_flush, busy3, err3;
  logic [19:0] out3_sum;
  logic [1:0]  out3_ch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  acc_multi #(.IN_W(16), .SUM_W(20), .NCH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .in_clr(in_clr), .sat_en(sat_en), .flush_req(flush_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ch(out_ch),
    .out_ovf(out_ovf), .out_flush(out_flush), .busy(busy), .err(err)
  );

  acc_multi #(.IN_W(16), .SUM_W(20), .NCH(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data), .in_ch(in3_ch),
    .in_clr(1'b0), .sat_en(1'b0), .flush_req(1'b0),
    .out_valid(out3_valid), .out_ready(1'b1), .out_sum(out3_sum), .out_ch(out3_ch),
    .out_ovf(out3_ovf), .out_flush(out3_flush), .busy(busy3), .err(err3)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input int ch, input int d, input bit clr, input bit sat);
    in_ch    = 2'(ch);
    in_data  = 16'(d);
    in_clr   = clr;
    sat_en   = sat;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_clr   = 1'b0;
  endtask

  task automatic beat3(input int ch, input int d);
    in3_ch    = 2'(ch);
    in3_data  = 16'(d);
    in3_valid = 1'b1;
    @(posedge clk);
    #1;
    in3_valid = 1'b0;
  endtask

  int flush_sum [4] = '{10, -3, 0, 9};

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_sum", signed'(out_sum), 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);

    beat(1, 5, 0, 0);
    check("first_valid", out_valid, 1);
    check("first_sum", signed'(out_sum), 5);
    check("first_ch", out_ch, 1);
    check("first_ovf", out_ovf, 0);
    check("first_flush", out_flush, 0);

    // saturate on ch2
    for (int i = 1; i <= 17; i++) begin
      beat(2, 32767, 0, 1);
      if (i == 16) begin
        check("sat16_sum", signed'(out_sum), 524272);
        check("sat16_ovf", out_ovf, 0);
      end
    end
    check("sat17_sum", signed'(out_sum), 524287);
    check("sat17_ovf", out_ovf, 1);
    beat(2, -1, 0, 1);
    check("sat_dec_sum", signed'(out_sum), 524286);
    check("sat_dec_ovf", out_ovf, 1);

    // wrap on ch3
    for (int i = 1; i <= 17; i++) begin
      beat(3, 32767, 0, 0);
      if (i == 16) check("wrap16_sum", signed'(out_sum), 524272);
    end
    check("wrap17_sum", signed'(out_sum), -491537);
    check("wrap17_ovf", out_ovf, 1);
    check("wrap17_ch", out_ch, 3);
    beat(3, 7, 1, 0);
    check("clr_sum", signed'(out_sum), 7);
    check("clr_ovf", out_ovf, 0);

    // back-to-back with backpressure on ch0
    in_ch = 2'd0; in_data = 16'd1; in_clr = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("bp_first", signed'(out_sum), 1);
    out_ready = 1'b0;
    in_data = 16'd2;
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", signed'(out_sum), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_second", signed'(out_sum), 3);
    in_data = 16'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_third", signed'(out_sum), 6);
    check("bp_third_ch", out_ch, 0);

    // flush with a same-edge beat on ch1
    beat(0, 10, 1, 0);
    beat(1, -4, 1, 0);
    beat(2, 0, 1, 0);
    beat(3, 9, 1, 0);
    in_ch = 2'd1; in_data = 16'd1; in_clr = 1'b0; in_valid = 1'b1; flush_req = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush_req = 1'b0;
    check("fl_beat_sum", signed'(out_sum), -3);
    check("fl_beat_flush", out_flush, 0);
    check("fl_busy0", busy, 1);
    check("fl_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("fl_valid", out_valid, 1);
      check("fl_ch", out_ch, i);
      check("fl_sum", signed'(out_sum), flush_sum[i]);
      check("fl_flag", out_flush, 1);
      check("fl_ovf", out_ovf, 0);
      check("fl_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    check("fl_done_busy", busy, 0);
    check("fl_done_valid", out_valid, 0);
    for (int c = 0; c < 4; c++) begin
      beat(c, 1, 0, 0);
      check("post_fl_sum", signed'(out_sum), 1);
      check("post_fl_ch", out_ch, c);
    end

    // out-of-range channel on the 3-channel instance
    beat3(0, 11);
    check("e3_load", signed'(out3_sum), 11);
    check("e3_err0", err3, 0);
    beat3(3, 5);
    check("e3_err", err3, 1);
    check("e3_no_out", out3_valid, 0);
    @(posedge clk);
    #1;
    check("e3_err_pulse", err3, 0);
    beat3(0, 1);
    check("e3_unchanged", signed'(out3_sum), 12);

    // reset during the second flush output
    @(posedge clk);
    #1;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    check("ab_busy", busy, 1);
    @(posedge clk);
    #1;
    check("ab_out0_ch", out_ch, 0);
    check("ab_out0_sum", signed'(out_sum), 1);
    @(posedge clk);
    #1;
    check("ab_out1_ch", out_ch, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("ab_valid", out_valid, 0);
    check("ab_sum", signed'(out_sum), 0);
    check("ab_ch", out_ch, 0);
    check("ab_ovf", out_ovf, 0);
    check("ab_flush", out_flush, 0);
    check("ab_busy_rst", busy, 0);
    @(posedge clk);
    #1;
    check("ab_no_more", out_valid, 0);
    check("ab_idle", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      beat(c, 0, 0, 0);
      check("ab_zero_sum", signed'(out_sum), 0);
      check("ab_zero_ovf", out_ovf, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
